// File: rtl/nibble_accumulator_pkg.sv
// ============================================================================
// Module   : nibble_accumulator_pkg
// Brief    : State encoding and saturation constants for nibble_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] SAT_POS = 4'b0111;
  localparam logic [3:0] SAT_NEG = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/nibble_accumulator_if.sv
// ============================================================================
// Module   : nibble_accumulator_if
// Brief    : Command, operand and result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_accumulator_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             in_valid;
  logic [3:0]       in_data;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_sum;
  logic             res_overflow;
  logic [CNT_W-1:0] res_carries;
  logic             busy;

  modport master (
    output start, in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_sum, res_overflow, res_carries, busy
  );

  modport slave (
    input  start, in_valid, in_data, res_ready,
    output in_ready, res_valid, res_sum, res_overflow, res_carries, busy
  );
endinterface

`default_nettype wire

// File: rtl/nibble_accumulator_add4_ovf.sv
// ============================================================================
// Module   : add4_ovf
// Brief    : 4-bit add, carry-in 0, with carryout and signed overflow (c3^c4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add4_ovf (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  output logic      [3:0] sum,
  output logic            carryout,
  output logic            overflow
);
  logic [3:0] w_low;
  logic [4:0] w_full;

  // Carry into bit 3 comes from the lower three bits alone.
  assign w_low    = {1'b0, a[2:0]} + {1'b0, b[2:0]};
  assign w_full   = {1'b0, a} + {1'b0, b};
  assign sum      = w_full[3:0];
  assign carryout = w_full[4];
  assign overflow = w_low[3] ^ w_full[4];
endmodule

`default_nettype wire

// File: rtl/nibble_accumulator.sv
// ============================================================================
// Module   : nibble_accumulator
// Brief    : Accumulates NUM_OPS signed nibbles; reports sum, sticky overflow
//            and carry count on a result handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_accumulator
  import nibble_accumulator_pkg::*;
#(
  parameter int NUM_OPS  = 4,
  parameter int CNT_W    = 3,
  parameter int SATURATE = 0
) (
  input wire logic           clk,
  input wire logic           reset_n,
  nibble_accumulator_if.slave bus
);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_OPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_carries;

  logic [3:0]       w_sum;
  logic             w_c4;
  logic             w_ovf;
  logic [3:0]       w_acc_nxt;
  logic             w_accept;

  add4_ovf u_add (
    .a        (r_acc),
    .b        (bus.in_data),
    .sum      (w_sum),
    .carryout (w_c4),
    .overflow (w_ovf)
  );

  if (SATURATE != 0) begin : g_sat
    assign w_acc_nxt = w_ovf ? (bus.in_data[3] ? SAT_NEG : SAT_POS) : w_sum;
  end else begin : g_wrap
    assign w_acc_nxt = w_sum;
  end

  assign w_accept = (r_state == ST_ACCUM) && bus.in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Handshake outputs decode from registered state only.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid && (r_cnt == C_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.res_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_carries <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_carries <= '0;
    end else if (w_accept) begin
      r_acc     <= w_acc_nxt;
      r_cnt     <= r_cnt + CNT_W'(1);
      r_ovf     <= r_ovf | w_ovf;
      r_carries <= r_carries + CNT_W'(w_c4);
    end
  end

  assign bus.res_sum      = r_acc;
  assign bus.res_overflow = r_ovf;
  assign bus.res_carries  = r_carries;
endmodule

`default_nettype wire
